dram_cache: RTL and testbench

Direct-mapped, write-back cache of 64-bit user records, sitting directly upstream of the DRAM bridge. It accepts single-record read/write requests from the core, answers hits locally, and issues bridge transactions (C_* port group) only for misses, dirty evictions and flushes. The bridge adds the 0x10000 base and the ×8 stride itself, so this block deals only in 8-bit record addresses.

---
 rtl/dram_cache.sv | 230 +++++++++++++++++++++++
 tb/tb_dram_cache.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cache.sv
// rtl/dram_cache.sv - direct-mapped write-back record cache in front of the DRAM bridge
// Hits are served locally; bridge traffic only for misses, dirty evictions and flush.
module dram_cache #(
   parameter int ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [7:0]  req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_data,
   input  logic        flush_req,
   output logic        flush_done,
   output logic        C_in_valid,
   output logic        C_r_wb,
   output logic [7:0]  C_addr,
   output logic [63:0] C_data_w,
   input  logic        C_out_valid,
   input  logic [63:0] C_data_r
);

   localparam int IDX = $clog2(ENTRIES);
   localparam int TW  = 8 - IDX;

   typedef enum logic [3:0] {
      IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP, FL_SCAN, FL_WAIT, FL_DONE
   } state_t;

   state_t state, state_n;

   logic [ENTRIES-1:0] valid_q, dirty_q;
   logic [TW-1:0]      tag_q  [ENTRIES];
   logic [63:0]        data_q [ENTRIES];

   logic        lat_wr;
   logic [7:0]  lat_addr;
   logic [63:0] lat_wdata;
   logic [IDX-1:0] ptr, ptr_n;

   logic           accept;
   logic           resp_valid_n, flush_done_n, c_in_valid_n, c_r_wb_n;
   logic [63:0]    resp_data_n, c_data_w_n;
   logic [7:0]     c_addr_n;
   logic           line_we, line_dirty, clr_dirty;
   logic [IDX-1:0] line_idx, clr_idx;
   logic [TW-1:0]  line_tag;
   logic [63:0]    line_data;

   logic [IDX-1:0] req_idx, lat_idx;
   logic [TW-1:0]  req_tag, lat_tag;
   logic           hit, ptr_last;

   assign req_idx  = req_addr[IDX-1:0];
   assign req_tag  = req_addr[7:IDX];
   assign lat_idx  = lat_addr[IDX-1:0];
   assign lat_tag  = lat_addr[7:IDX];
   assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign ptr_last = (ptr == IDX'(ENTRIES - 1));

   // Held low during reset so the block looks idle-but-unavailable until release.
   assign req_ready = (state == IDLE) && !rst;

   always_comb begin
      state_n      = state;
      ptr_n        = ptr;
      accept       = 1'b0;
      resp_valid_n = 1'b0;
      resp_data_n  = 64'd0;
      flush_done_n = 1'b0;
      c_in_valid_n = 1'b0;
      c_r_wb_n     = C_r_wb;
      c_addr_n     = C_addr;
      c_data_w_n   = C_data_w;
      line_we      = 1'b0;
      line_idx     = lat_idx;
      line_tag     = lat_tag;
      line_data    = lat_wdata;
      line_dirty   = 1'b0;
      clr_dirty    = 1'b0;
      clr_idx      = lat_idx;

      case (state)
         IDLE: begin
            if (flush_req) begin
               state_n = FL_SCAN;
               ptr_n   = '0;
            end else if (req_valid) begin
               accept = 1'b1;
               if (hit || !(valid_q[req_idx] && dirty_q[req_idx])) begin
                  if (req_wr) begin
                     line_we      = 1'b1;
                     line_idx     = req_idx;
                     line_tag     = req_tag;
                     line_data    = req_wdata;
                     line_dirty   = 1'b1;
                     resp_valid_n = 1'b1;
                     resp_data_n  = req_wdata;
                     state_n      = RESP;
                  end else if (hit) begin
                     resp_valid_n = 1'b1;
                     resp_data_n  = data_q[req_idx];
                     state_n      = RESP;
                  end else begin
                     c_in_valid_n = 1'b1;
                     c_r_wb_n     = 1'b1;
                     c_addr_n     = req_addr;
                     state_n      = RD_REQ;
                  end
               end else begin
                  c_in_valid_n = 1'b1;
                  c_r_wb_n     = 1'b0;
                  c_addr_n     = {tag_q[req_idx], req_idx};
                  c_data_w_n   = data_q[req_idx];
                  state_n      = WB_REQ;
               end
            end
         end
         WB_REQ: state_n = WB_WAIT;
         WB_WAIT: begin
            if (C_out_valid) begin
               if (lat_wr) begin
                  line_we      = 1'b1;
                  line_dirty   = 1'b1;
                  resp_valid_n = 1'b1;
                  resp_data_n  = lat_wdata;
                  state_n      = RESP;
               end else begin
                  clr_dirty    = 1'b1;
                  c_in_valid_n = 1'b1;
                  c_r_wb_n     = 1'b1;
                  c_addr_n     = lat_addr;
                  state_n      = RD_REQ;
               end
            end
         end
         RD_REQ: state_n = RD_WAIT;
         RD_WAIT: begin
            if (C_out_valid) begin
               line_we      = 1'b1;
               line_data    = C_data_r;
               resp_valid_n = 1'b1;
               resp_data_n  = C_data_r;
               state_n      = RESP;
            end
         end
         RESP: state_n = IDLE;
         FL_SCAN: begin
            if (valid_q[ptr] && dirty_q[ptr]) begin
               c_in_valid_n = 1'b1;
               c_r_wb_n     = 1'b0;
               c_addr_n     = {tag_q[ptr], ptr};
               c_data_w_n   = data_q[ptr];
               state_n      = FL_WAIT;
            end else if (ptr_last) begin
               flush_done_n = 1'b1;
               state_n      = FL_DONE;
            end else begin
               ptr_n = ptr + 1'b1;
            end
         end
         FL_WAIT: begin
            if (C_out_valid) begin
               clr_dirty = 1'b1;
               clr_idx   = ptr;
               if (ptr_last) begin
                  flush_done_n = 1'b1;
                  state_n      = FL_DONE;
               end else begin
                  ptr_n   = ptr + 1'b1;
                  state_n = FL_SCAN;
               end
            end
         end
         FL_DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         lat_wr     <= 1'b0;
         lat_addr   <= 8'd0;
         lat_wdata  <= 64'd0;
         resp_valid <= 1'b0;
         resp_data  <= 64'd0;
         flush_done <= 1'b0;
         C_in_valid <= 1'b0;
         C_r_wb     <= 1'b0;
         C_addr     <= 8'd0;
         C_data_w   <= 64'd0;
         valid_q    <= '0;
         dirty_q    <= '0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         resp_valid <= resp_valid_n;
         resp_data  <= resp_data_n;
         flush_done <= flush_done_n;
         C_in_valid <= c_in_valid_n;
         C_r_wb     <= c_r_wb_n;
         C_addr     <= c_addr_n;
         C_data_w   <= c_data_w_n;
         if (accept) begin
            lat_wr    <= req_wr;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
         end
         // An install on the evicted index supersedes the dirty clear.
         if (line_we) begin
            valid_q[line_idx] <= 1'b1;
            dirty_q[line_idx] <= line_dirty;
         end else if (clr_dirty) begin
            dirty_q[clr_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[line_idx]  <= line_tag;
         data_q[line_idx] <= line_data;
      end
   end

endmodule

// File: tb/tb_dram_cache.sv
// tb/tb_dram_cache.sv - directed self-checking bench for dram_cache
// Inputs change and outputs are sampled on the falling edge.
module tb_dram_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr;
   logic [7:0]  req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        flush_req, flush_done;
   logic        C_in_valid, C_r_wb;
   logic [7:0]  C_addr;
   logic [63:0] C_data_w;
   logic        C_out_valid;
   logic [63:0] C_data_r;

   int tests = 0;
   int fails = 0;

   dram_cache #(.ENTRIES(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .flush_req(flush_req), .flush_done(flush_done),
      .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr),
      .C_data_w(C_data_w), .C_out_valid(C_out_valid), .C_data_r(C_data_r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic req(input logic wr, input logic [7:0] a, input logic [63:0] d);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
      flush_req = 0; C_out_valid = 0; C_data_r = 0;

      // reset
      step(); step();
      chk("rst_ready", req_ready, 0);
      chk("rst_resp", resp_valid, 0);
      chk("rst_cin", C_in_valid, 0);
      chk("rst_addr", C_addr, 0);
      chk("rst_fdone", flush_done, 0);
      rst = 1'b0;
      step(); step();
      chk("idle_ready", req_ready, 1);
      chk("idle_cin", C_in_valid, 0);

      // clean read miss on 0x05
      req(0, 8'h05, 0);
      step();
      req_valid = 0;
      chk("rm_cin", C_in_valid, 1);
      chk("rm_rwb", C_r_wb, 1);
      chk("rm_addr", C_addr, 8'h05);
      chk("rm_ready", req_ready, 0);
      step();
      chk("rm_cin_pulse", C_in_valid, 0);
      C_out_valid = 1; C_data_r = 64'h1122334455667788;
      step();
      C_out_valid = 0; C_data_r = 0;
      chk("rm_resp", resp_valid, 1);
      chk("rm_data", resp_data, 64'h1122334455667788);
      step();
      chk("rm_resp_end", resp_valid, 0);
      chk("rm_data_zero", resp_data, 0);
      chk("rm_ready_back", req_ready, 1);

      // read hit on 0x05
      req(0, 8'h05, 0);
      step();
      req_valid = 0;
      chk("rh_resp", resp_valid, 1);
      chk("rh_data", resp_data, 64'h1122334455667788);
      chk("rh_cin", C_in_valid, 0);
      step();
      chk("rh_ready", req_ready, 1);

      // write hit 0x05 <- 0xA
      req(1, 8'h05, 64'hA);
      step();
      req_valid = 0;
      chk("wh_resp", resp_valid, 1);
      chk("wh_data", resp_data, 64'hA);
      chk("wh_cin", C_in_valid, 0);
      step();

      // read 0x09: dirty eviction of 0x05 then fill
      req(0, 8'h09, 0);
      step();
      req_valid = 0;
      chk("ev_cin", C_in_valid, 1);
      chk("ev_rwb", C_r_wb, 0);
      chk("ev_addr", C_addr, 8'h05);
      chk("ev_dataw", C_data_w, 64'hA);
      step();
      chk("ev_hold_addr", C_addr, 8'h05);
      chk("ev_hold_cin", C_in_valid, 0);
      C_out_valid = 1;
      step();
      C_out_valid = 0;
      chk("ev_rd_cin", C_in_valid, 1);
      chk("ev_rd_rwb", C_r_wb, 1);
      chk("ev_rd_addr", C_addr, 8'h09);
      chk("ev_rd_noresp", resp_valid, 0);
      step();
      C_out_valid = 1; C_data_r = 64'hCAFE0009;
      step();
      C_out_valid = 0; C_data_r = 0;
      chk("ev_resp", resp_valid, 1);
      chk("ev_data", resp_data, 64'hCAFE0009);
      step();

      // clean write miss 0x02
      req(1, 8'h02, 64'hBEEF);
      step();
      req_valid = 0;
      chk("cw_resp", resp_valid, 1);
      chk("cw_data", resp_data, 64'hBEEF);
      chk("cw_cin", C_in_valid, 0);
      step();
      chk("cw_ready", req_ready, 1);

      // write 0x05 over clean 0x09: no traffic, line 1 dirty again
      req(1, 8'h05, 64'h55);
      step();
      req_valid = 0;
      chk("cw2_resp", resp_valid, 1);
      chk("cw2_cin", C_in_valid, 0);
      step();

      // flush with dirty lines at index 1 and 2
      flush_req = 1;
      step();
      flush_req = 0;
      chk("fl_ready", req_ready, 0);
      chk("fl_scan0", C_in_valid, 0);
      step();
      chk("fl_scan1", C_in_valid, 0);
      step();
      chk("fl1_cin", C_in_valid, 1);
      chk("fl1_rwb", C_r_wb, 0);
      chk("fl1_addr", C_addr, 8'h05);
      chk("fl1_data", C_data_w, 64'h55);
      step();
      C_out_valid = 1;
      step();
      C_out_valid = 0;
      chk("fl_scan2", C_in_valid, 0);
      chk("fl_nodone1", flush_done, 0);
      step();
      chk("fl2_cin", C_in_valid, 1);
      chk("fl2_addr", C_addr, 8'h02);
      chk("fl2_data", C_data_w, 64'hBEEF);
      step();
      C_out_valid = 1;
      step();
      C_out_valid = 0;
      chk("fl_scan3", flush_done, 0);
      step();
      chk("fl_done", flush_done, 1);
      step();
      chk("fl_done_pulse", flush_done, 0);
      chk("fl_ready_back", req_ready, 1);

      // second flush with a competing request: flush wins, nothing dirty
      flush_req = 1;
      req(0, 8'h05, 0);
      step();
      flush_req = 0;
      req_valid = 0;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("fl2_scan_cin%0d", i), C_in_valid, 0);
         chk($sformatf("fl2_scan_resp%0d", i), resp_valid, 0);
         chk($sformatf("fl2_scan_done%0d", i), flush_done, 0);
         step();
      end
      chk("fl2_done", flush_done, 1);
      step();

      // lines remain valid after flush
      req(0, 8'h02, 0);
      step();
      req_valid = 0;
      chk("pf_resp", resp_valid, 1);
      chk("pf_data", resp_data, 64'hBEEF);
      chk("pf_cin", C_in_valid, 0);
      step();

      // reset during RD_WAIT
      req(0, 8'h0D, 0);
      step();
      req_valid = 0;
      chk("rr_cin", C_in_valid, 1);
      chk("rr_addr", C_addr, 8'h0D);
      step();
      rst = 1;
      #1;
      chk("rr_addr_clr", C_addr, 0);
      chk("rr_rwb_clr", C_r_wb, 0);
      chk("rr_ready_clr", req_ready, 0);
      step();
      rst = 0;
      C_out_valid = 1; C_data_r = 64'hDEAD;
      step();
      C_out_valid = 0; C_data_r = 0;
      chk("rr_late_resp", resp_valid, 0);
      chk("rr_late_cin", C_in_valid, 0);
      chk("rr_ready", req_ready, 1);
      req(0, 8'h05, 0);
      step();
      req_valid = 0;
      chk("rr_miss_cin", C_in_valid, 1);
      chk("rr_miss_addr", C_addr, 8'h05);
      chk("rr_miss_noresp", resp_valid, 0);
      step();
      C_out_valid = 1; C_data_r = 64'h77;
      step();
      C_out_valid = 0;
      chk("rr_resp", resp_data, 64'h77);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
